// File: rtl/seq_divider_if.sv
// Request/response bundle between the execute-stage pipeline and seq_divider.
// The pipeline drives the master side; the divider is the slave.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle.
// Define SEQ_DIVIDER_SIGNED_EN to honour is_signed; otherwise every operation is unsigned.
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  seq_divider_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_pend;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_dbz;
  logic [CNT_W-1:0] r_cnt;

  logic             w_busy;
  logic             w_accept;
  logic             w_launch;
  logic             w_zero;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_abs_dvd;
  logic [WIDTH-1:0] w_abs_dvs;
  logic [WIDTH-1:0] w_fix_q;
  logic [WIDTH-1:0] w_fix_r;

  // An accepted start spends one IDLE cycle with r_pend set while the
  // latched divisor is tested, so busy covers that cycle too.
  assign w_busy   = r_pend | (r_state == RUN) | (r_state == FIX);
  assign w_accept = bus.start & ~w_busy;
  assign w_launch = (r_state == IDLE) & r_pend;
  assign w_zero   = (r_dvs == '0);

  assign w_shift  = {r_rem, r_q[WIDTH-1]};
  assign w_trial  = w_shift - {1'b0, r_mag};

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic r_sgn;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_sgn <= 1'b0;
    else if (w_accept) r_sgn <= bus.is_signed;
  end

  // Magnitudes are plain unsigned values; 0x80000000 maps onto itself.
  assign w_abs_dvd = (r_sgn & r_dvd[WIDTH-1]) ? -r_dvd : r_dvd;
  assign w_abs_dvs = (r_sgn & r_dvs[WIDTH-1]) ? -r_dvs : r_dvs;
  assign w_fix_q   = (r_sgn & (r_dvd[WIDTH-1] ^ r_dvs[WIDTH-1])) ? -r_q : r_q;
  assign w_fix_r   = (r_sgn & r_dvd[WIDTH-1]) ? -r_rem : r_rem;
`else
  assign w_abs_dvd = r_dvd;
  assign w_abs_dvs = r_dvs;
  assign w_fix_q   = r_q;
  assign w_fix_r   = r_rem;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave w_next unassigned and infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_launch) w_next = w_zero ? DONE : RUN;
      RUN:  if (r_cnt == CNT_W'(1)) w_next = FIX;
      FIX:  w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_pend <= 1'b0;
    else if (w_accept) r_pend <= 1'b1;
    else if (w_launch) r_pend <= 1'b0;
  end

  // NOTE: state updates use non-blocking assignments so every register here
  // samples the pre-edge values; the operand latches and working registers are
  // reset too, so nothing observable depends on power-up contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_rem  <= '0;
      r_q    <= '0;
      r_mag  <= '0;
      r_quot <= '0;
      r_remo <= '0;
      r_dbz  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_dvd <= bus.dividend;
        r_dvs <= bus.divisor;
      end

      if (w_launch) begin
        if (w_zero) begin
          r_quot <= '1;
          r_remo <= r_dvd;
          r_dbz  <= 1'b1;
        end else begin
          r_rem <= '0;
          r_q   <= w_abs_dvd;
          r_mag <= w_abs_dvs;
          r_cnt <= CNT_W'(WIDTH);
        end
      end

      if (r_state == RUN) begin
        if (!w_trial[WIDTH]) begin
          r_rem <= w_trial[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], 1'b1};
        end else begin
          r_rem <= w_shift[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], 1'b0};
        end
        r_cnt <= r_cnt - CNT_W'(1);
      end

      // Outputs only move here or on the divide-by-zero launch.
      if (r_state == FIX) begin
        r_quot <= w_fix_q;
        r_remo <= w_fix_r;
        r_dbz  <= 1'b0;
      end
    end
  end

  assign bus.busy        = w_busy;
  assign bus.done        = (r_state == DONE);
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_remo;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: arithmetic reference model with per-cycle compare,
// directed literal cases, then randomized traffic including ignored starts.
module tb_seq_divider;

  localparam int WIDTH = 32;
`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } res_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(WIDTH)) bus ();

  seq_divider #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic res_t ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    res_t   res;
    longint sa;
    longint sb;
    if (b == 32'd0) begin
      res.q   = 32'hFFFF_FFFF;
      res.r   = a;
      res.dbz = 1'b1;
    end else if (sgn && SIGNED_BUILD) begin
      sa      = longint'($signed(a));
      sb      = longint'($signed(b));
      res.q   = 32'(sa / sb);
      res.r   = 32'(sa % sb);
      res.dbz = 1'b0;
    end else begin
      res.q   = a / b;
      res.r   = a % b;
      res.dbz = 1'b0;
    end
    return res;
  endfunction

  // Reference: an accepted start is busy for WIDTH+2 cycles (1 for a zero
  // divisor), then results appear together with a one-cycle done.
  int   m_cnt;
  logic m_busy;
  logic m_done;
  res_t m_res;
  res_t m_pend;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt  <= 0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_pend <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt == 1) begin
        m_res  <= m_pend;
        m_done <= 1'b1;
        m_busy <= 1'b0;
      end
      if (m_cnt > 0) m_cnt <= m_cnt - 1;
      if (bus.start && !m_busy) begin
        m_pend <= ref_div(bus.dividend, bus.divisor, bus.is_signed);
        m_busy <= 1'b1;
        m_cnt  <= (bus.divisor == 32'd0) ? 1 : WIDTH + 2;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("busy",        32'(bus.busy),        32'(m_busy));
      check("done",        32'(bus.done),        32'(m_done));
      check("quotient",    bus.quotient,         m_res.q);
      check("remainder",   bus.remainder,        m_res.r);
      check("div_by_zero", 32'(bus.div_by_zero), 32'(m_res.dbz));
    end
  end

  // Called at a negedge; start is seen by the following posedge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.dividend  = a;
    bus.divisor   = b;
    bus.is_signed = s;
    bus.start     = 1'b1;
    @(posedge clk);
    #1 bus.start  = 1'b0;
  endtask

  // Counts posedges after the accepting edge until done is seen; returns at a negedge.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!bus.done && lat < 100);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int exp_lat,
                        input logic [31:0] eq, input logic [31:0] er, input logic edbz);
    int lat;
    start_op(a, b, s);
    wait_done(lat);
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".q"},       bus.quotient, eq);
    check({tag, ".r"},       bus.remainder, er);
    check({tag, ".dbz"},     32'(bus.div_by_zero), 32'(edbz));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(negedge clk);
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.done", 32'(bus.done), 32'd0);
    check("reset.q",    bus.quotient, 32'd0);
    check("reset.r",    bus.remainder, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run_op("divu_100_7", 32'd100, 32'd7, 1'b0, WIDTH + 2, 32'd14, 32'd2, 1'b0);
    run_op("divu_neg100_7", 32'hFFFF_FF9C, 32'd7, 1'b0, WIDTH + 2, 32'h2492_4916, 32'd2, 1'b0);
    run_op("div_neg100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, WIDTH + 2,
           SIGNED_BUILD ? 32'hFFFF_FFF2 : 32'h2492_4916,
           SIGNED_BUILD ? 32'hFFFF_FFFE : 32'd2, 1'b0);
    run_op("div_zero", 32'h1234_5678, 32'd0, 1'b1, 1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    run_op("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, WIDTH + 2,
           SIGNED_BUILD ? 32'h8000_0000 : 32'd0,
           SIGNED_BUILD ? 32'd0 : 32'h8000_0000, 1'b0);
    // Issued in the DONE cycle of the previous operation.
    run_op("b2b", 32'hFFFF_FFFF, 32'h10, 1'b0, WIDTH + 2, 32'h0FFF_FFFF, 32'hF, 1'b0);

    // Abort by reset: an ignored start at cycle 10, reset at cycle 20.
    start_op(32'd1000, 32'd3, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 10) begin
        bus.dividend = 32'd5;
        bus.divisor  = 32'd5;
        bus.start    = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
    end
    #2 reset_n = 1'b0;
    #1;
    check("abort.busy", 32'(bus.busy), 32'd0);
    check("abort.done", 32'(bus.done), 32'd0);
    check("abort.q",    bus.quotient, 32'd0);
    check("abort.r",    bus.remainder, 32'd0);
    check("abort.dbz",  32'(bus.div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    run_op("after_reset", 32'd9, 32'd3, 1'b0, WIDTH + 2, 32'd3, 32'd0, 1'b0);

    // Random traffic; starts while busy must be ignored by the DUT.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.start     = ($urandom_range(0, 3) == 0);
      bus.is_signed = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 7))
        0:       bus.dividend = 32'h8000_0000;
        1:       bus.dividend = 32'd0;
        2:       bus.dividend = 32'($urandom_range(0, 255));
        default: bus.dividend = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       bus.divisor = 32'd0;
        1, 2:    bus.divisor = 32'($urandom_range(1, 15));
        3:       bus.divisor = 32'hFFFF_FFFF;
        default: bus.divisor = $urandom;
      endcase
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (WIDTH + 8) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
